// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus bundle.
// Groups the imem request/response channel, the branch/jump redirect inputs and the
// decode-side instruction channel of inst_fetch_unit.
//   master : the fetch unit (drives requests, instruction head, fetch_pc, proto_err)
//   slave  : the environment (imem, branch/jump resolution, decode)
interface inst_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  // imem request channel
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  // imem response channel (in request order, at most one per cycle)
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  // redirects
  logic            br_valid;
  logic [XLEN-1:0] br_pc;
  logic [15:0]     br_imm;
  logic            jmp_valid;
  logic [XLEN-1:0] jmp_pc;
  logic [25:0]     jmp_idx;
  // decode channel
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;
  // status
  logic [XLEN-1:0] fetch_pc;
  logic            proto_err;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, fetch_pc,
           proto_err,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, br_valid, br_pc, br_imm,
           jmp_valid, jmp_pc, jmp_idx, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, fetch_pc,
           proto_err,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, br_valid, br_pc, br_imm,
           jmp_valid, jmp_pc, jmp_idx, inst_ready
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit.
// Owns the PC, issues pipelined imem requests over valid/ready, tags returned words with
// their PC and buffers them in an instruction queue that drains to decode as {inst, pc}.
// Branch/jump redirects flush the queue and turn every in-flight request into a word that
// is silently dropped when it returns.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : inst_fetch_unit_if.master (imem req/rsp, redirects, decode channel, status)
module inst_fetch_unit #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR    = '0,
  parameter int unsigned     FQ_DEPTH        = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_unit_if.master bus
);

  localparam int unsigned QW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]   out_q, out_d;     // accepted-but-unanswered requests, doomed ones included
  logic [OW-1:0]   drop_q, drop_d;   // how many of those will be discarded on return
  logic [CW-1:0]   q_cnt_q, q_cnt_d;
  logic [QW-1:0]   q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [PW-1:0]   pf_wr_q, pf_wr_d, pf_rd_q, pf_rd_d;
  logic            proto_err_q, proto_err_d;
  logic            run_q;            // holds req_valid low for the first cycle out of reset

  logic [31:0]     q_inst [FQ_DEPTH];
  logic [XLEN-1:0] q_pc   [FQ_DEPTH];
  logic [XLEN-1:0] pf_mem [MAX_OUTSTANDING];  // issued addresses awaiting a live response

  logic            redirect, req_fire, rsp_ok, rsp_live, push, pop, q_nonempty, credit_ok;
  logic [XLEN-1:0] br_target, jmp_pc4, jmp_target, redirect_target;

  function automatic logic [PW-1:0] pf_inc(logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Redirect targets; jump wins when both are asserted.
  assign br_target       = bus.br_pc + XLEN'(4)
                         + {{(XLEN-18){bus.br_imm[15]}}, bus.br_imm, 2'b00};
  assign jmp_pc4         = bus.jmp_pc + XLEN'(4);
  assign jmp_target      = {jmp_pc4[XLEN-1:28], bus.jmp_idx, 2'b00};
  assign redirect        = bus.br_valid | bus.jmp_valid;
  assign redirect_target = bus.jmp_valid ? jmp_target : br_target;

  // Counting every in-flight request against queue space guarantees a slot for each
  // returning word, so a push never meets a full queue.
  assign credit_ok = (32'(q_cnt_q) + 32'(out_q)) < FQ_DEPTH;

  assign bus.imem_req_valid = run_q & ~redirect & (out_q < OW'(MAX_OUTSTANDING)) & credit_ok;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.fetch_pc       = fetch_pc_q;
  assign bus.proto_err      = proto_err_q;

  assign q_nonempty     = (q_cnt_q != '0);
  assign bus.inst_valid = q_nonempty & ~redirect;
  assign bus.inst_data  = q_nonempty ? q_inst[q_rd_q] : '0;
  assign bus.inst_pc    = q_nonempty ? q_pc[q_rd_q] : '0;

  assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp_ok   = bus.imem_rsp_valid & (out_q != '0);
  assign rsp_live = rsp_ok & (drop_q == '0);
  assign push     = rsp_live & ~redirect;
  assign pop      = bus.inst_valid & bus.inst_ready;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    out_d       = out_q + OW'(req_fire) - OW'(rsp_ok);
    drop_d      = drop_q;
    q_cnt_d     = q_cnt_q;
    q_wr_d      = q_wr_q;
    q_rd_d      = q_rd_q;
    pf_wr_d     = pf_wr_q;
    pf_rd_d     = pf_rd_q;
    proto_err_d = proto_err_q | (bus.imem_rsp_valid & (out_q == '0));

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
      pf_wr_d    = pf_inc(pf_wr_q);
    end

    if (redirect) begin
      // Every request still in flight after this edge becomes a drop.
      fetch_pc_d = redirect_target;
      drop_d     = out_q - OW'(rsp_ok);
      q_cnt_d    = '0;
      q_wr_d     = '0;
      q_rd_d     = '0;
      pf_wr_d    = '0;
      pf_rd_d    = '0;
    end else begin
      if (rsp_ok && (drop_q != '0)) drop_d = drop_q - 1'b1;
      if (rsp_live) pf_rd_d = pf_inc(pf_rd_q);
      if (push) q_wr_d = q_wr_q + 1'b1;
      if (pop) q_rd_d = q_rd_q + 1'b1;
      q_cnt_d = q_cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= RESET_VECTOR;
      out_q       <= '0;
      drop_q      <= '0;
      q_cnt_q     <= '0;
      q_wr_q      <= '0;
      q_rd_q      <= '0;
      pf_wr_q     <= '0;
      pf_rd_q     <= '0;
      proto_err_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
      q_cnt_q     <= q_cnt_d;
      q_wr_q      <= q_wr_d;
      q_rd_q      <= q_rd_d;
      pf_wr_q     <= pf_wr_d;
      pf_rd_q     <= pf_rd_d;
      proto_err_q <= proto_err_d;
      run_q       <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by the counters and pointers above.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[q_wr_q] <= bus.imem_rsp_data;
      q_pc[q_wr_q]   <= pf_mem[pf_rd_q];
    end
    if (req_fire) pf_mem[pf_wr_q] <= bus.imem_req_addr;
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: behavioural imem (1-cycle latency, optional hold),
// decode sink, and a scoreboard of expected {inst, pc} pairs.
`timescale 1ns/1ps
module tb_inst_fetch_unit;
  localparam int unsigned XLEN = 32;

  typedef struct packed { logic [31:0] data; logic [31:0] pc; } exp_t;
  typedef struct packed { logic [31:0] addr; logic doomed; } infl_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_unit_if #(.XLEN(XLEN)) bus ();

  inst_fetch_unit #(
    .XLEN(XLEN), .RESET_VECTOR(32'h0), .FQ_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  exp_t        exp_q[$];
  infl_t       infl_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  int          pop_cnt = 0;
  logic [31:0] model_pc;
  logic [31:0] last_addr;
  logic        obs_req_valid, obs_inst_valid, obs_fire;
  logic        ready_v, mem_hold, force_rsp, br_v, jmp_v;
  logic [31:0] br_pc_v, jmp_pc_v;
  logic [15:0] br_imm_v;
  logic [25:0] jmp_idx_v;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  task automatic drive_idle();
    ready_v = 0; mem_hold = 0; force_rsp = 0; br_v = 0; jmp_v = 0;
    br_pc_v = '0; br_imm_v = '0; jmp_pc_v = '0; jmp_idx_v = '0;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.br_valid = 1'b0; bus.br_pc = '0; bus.br_imm = '0;
    bus.jmp_valid = 1'b0; bus.jmp_pc = '0; bus.jmp_idx = '0; bus.inst_ready = 1'b0;
  endtask

  // One clock: drive inputs after negedge, sample/score, then advance to the next negedge.
  task automatic cycle();
    infl_t       ent;
    exp_t        e;
    logic        redir;
    logic [31:0] pc4;
    redir = br_v | jmp_v;
    bus.br_valid = br_v;  bus.br_pc = br_pc_v;   bus.br_imm = br_imm_v;
    bus.jmp_valid = jmp_v; bus.jmp_pc = jmp_pc_v; bus.jmp_idx = jmp_idx_v;
    bus.inst_ready = ready_v;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    if (force_rsp) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data = 32'hBAD0_0BAD;
    end else if (!mem_hold && infl_q.size() > 0) begin
      ent = infl_q.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data = word_of(ent.addr);
      if (!ent.doomed && !redir) begin
        e.data = word_of(ent.addr);
        e.pc = ent.addr;
        exp_q.push_back(e);
      end
    end
    #1;
    n_assert++;
    if (bus.fetch_pc !== model_pc) begin
      n_fail++;
      $display("FAIL fetch_pc: got %h expected %h", bus.fetch_pc, model_pc);
    end
    obs_req_valid = bus.imem_req_valid;
    obs_inst_valid = bus.inst_valid;
    obs_fire = 1'b0;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      n_assert++;
      obs_fire = 1'b1;
      if (bus.imem_req_addr !== model_pc) begin
        n_fail++;
        $display("FAIL req_addr: got %h expected %h", bus.imem_req_addr, model_pc);
      end
      ent.addr = bus.imem_req_addr;
      ent.doomed = 1'b0;
      infl_q.push_back(ent);
      model_pc = model_pc + 32'd4;
      acc_cnt++;
      last_addr = bus.imem_req_addr;
    end
    if (bus.inst_valid && bus.inst_ready) begin
      n_assert++;
      pop_cnt++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL inst_unexpected: got pc %h data %h expected no output",
                 bus.inst_pc, bus.inst_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.inst_data !== e.data || bus.inst_pc !== e.pc) begin
          n_fail++;
          $display("FAIL inst_out: got pc %h data %h expected pc %h data %h",
                   bus.inst_pc, bus.inst_data, e.pc, e.data);
        end
      end
    end
    if (redir) begin
      for (int i = 0; i < infl_q.size(); i++) begin
        ent = infl_q[i];
        ent.doomed = 1'b1;
        infl_q[i] = ent;
      end
      exp_q.delete();
      if (jmp_v) begin
        pc4 = jmp_pc_v + 32'd4;
        model_pc = {pc4[31:28], jmp_idx_v, 2'b00};
      end else begin
        model_pc = br_pc_v + 32'd4 + {{14{br_imm_v[15]}}, br_imm_v, 2'b00};
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive_idle();
    exp_q.delete();
    infl_q.delete();
    model_pc = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Runs cycles until the next request handshake; a timeout counts as a failure.
  task automatic wait_accept(input string name, input logic [31:0] want);
    int a0;
    int k;
    a0 = acc_cnt;
    k = 0;
    while (acc_cnt == a0 && k < 20) begin
      cycle();
      k++;
    end
    n_assert++;
    if (acc_cnt == a0) begin
      n_fail++;
      $display("FAIL %s: got no request within 20 cycles expected addr %h", name, want);
    end else if (last_addr !== want) begin
      n_fail++;
      $display("FAIL %s: got addr %h expected %h", name, last_addr, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    model_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    n_assert += 6;
    if (bus.imem_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_req_valid: got %b expected 0", bus.imem_req_valid); end
    if (bus.inst_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_inst_valid: got %b expected 0", bus.inst_valid); end
    if (bus.inst_data !== 32'h0) begin n_fail++;
      $display("FAIL rst_inst_data: got %h expected 0", bus.inst_data); end
    if (bus.inst_pc !== 32'h0) begin n_fail++;
      $display("FAIL rst_inst_pc: got %h expected 0", bus.inst_pc); end
    if (bus.fetch_pc !== 32'h0) begin n_fail++;
      $display("FAIL rst_fetch_pc: got %h expected 0", bus.fetch_pc); end
    if (bus.proto_err !== 1'b0) begin n_fail++;
      $display("FAIL rst_proto_err: got %b expected 0", bus.proto_err); end
    rst = 1'b1;
    cycle();
    n_assert++;
    if (obs_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL first_cycle_req_valid: got %b expected 0", obs_req_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    ready_v = 1;
    pop_cnt = 0;
    repeat (24) cycle();
    n_assert++;
    if (pop_cnt != 21) begin n_fail++;
      $display("FAIL stream_rate: got %0d outputs expected 21", pop_cnt); end
  endtask

  task automatic test_stall();
    int a0;
    do_reset();
    ready_v = 0;
    a0 = acc_cnt;
    repeat (10) cycle();
    n_assert += 2;
    if (acc_cnt - a0 != 4) begin n_fail++;
      $display("FAIL stall_accepts: got %0d expected 4", acc_cnt - a0); end
    if (obs_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL stall_req_valid: got %b expected 0", obs_req_valid); end
    ready_v = 1;
    repeat (8) cycle();
  endtask

  task automatic test_branch();
    int k;
    ready_v = 1;
    mem_hold = 1;
    k = 0;
    while (infl_q.size() < 2 && k < 10) begin
      cycle();
      k++;
    end
    n_assert++;
    if (infl_q.size() != 2) begin n_fail++;
      $display("FAIL br_inflight: got %0d expected 2", infl_q.size()); end
    br_v = 1; br_pc_v = 32'h10; br_imm_v = 16'hFFFE;
    cycle();
    br_v = 0;
    mem_hold = 0;
    n_assert += 2;
    if (obs_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL br_cycle_req_valid: got %b expected 0", obs_req_valid); end
    if (obs_inst_valid !== 1'b0) begin n_fail++;
      $display("FAIL br_cycle_inst_valid: got %b expected 0", obs_inst_valid); end
    wait_accept("br_target", 32'h0000_000C);
    repeat (8) cycle();
  endtask

  task automatic test_jump();
    ready_v = 1;
    jmp_v = 1; jmp_pc_v = 32'h1000_0000; jmp_idx_v = 26'h40;
    br_v = 1; br_pc_v = 32'h200; br_imm_v = 16'h0001;
    cycle();
    jmp_v = 0; br_v = 0;
    wait_accept("jmp_target", 32'h1000_0100);
    repeat (6) cycle();
  endtask

  task automatic test_wrap();
    ready_v = 1;
    jmp_v = 1; jmp_pc_v = 32'hF000_0000; jmp_idx_v = 26'h3FF_FFFF;
    cycle();
    jmp_v = 0;
    wait_accept("wrap_top", 32'hFFFF_FFFC);
    cycle();
    n_assert += 2;
    if (obs_fire !== 1'b1) begin n_fail++;
      $display("FAIL wrap_no_stall: got fire %b expected 1", obs_fire); end
    if (last_addr !== 32'h0) begin n_fail++;
      $display("FAIL wrap_addr: got %h expected 00000000", last_addr); end
    repeat (6) cycle();
  endtask

  task automatic test_back_to_back();
    ready_v = 1;
    br_v = 1; br_pc_v = 32'h10; br_imm_v = 16'hFFFE;
    cycle();
    br_pc_v = 32'h100; br_imm_v = 16'h0010;
    cycle();
    br_v = 0;
    wait_accept("b2b_target", 32'h0000_0144);
    for (int i = 0; i < 200; i++) begin
      ready_v = ($urandom_range(0, 3) != 0);
      mem_hold = ($urandom_range(0, 3) == 0);
      if (i == 60 || i == 140) begin
        br_v = 1; br_pc_v = 32'h400 + 32'(i); br_pc_v[1:0] = 2'b00; br_imm_v = 16'h0020;
      end else if (i == 100) begin
        jmp_v = 1; jmp_pc_v = 32'h2000_0000; jmp_idx_v = 26'h123;
      end
      cycle();
      br_v = 0;
      jmp_v = 0;
    end
    mem_hold = 0;
    ready_v = 1;
    repeat (8) cycle();
  endtask

  task automatic test_proto_err();
    exp_t head;
    int   k;
    ready_v = 0;
    k = 0;
    cycle();
    while ((obs_req_valid || infl_q.size() != 0) && k < 20) begin
      cycle();
      k++;
    end
    n_assert++;
    if (obs_req_valid || infl_q.size() != 0) begin n_fail++;
      $display("FAIL proto_idle: got req_valid %b inflight %0d expected 0 and 0",
               obs_req_valid, infl_q.size()); end
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    force_rsp = 1;
    cycle();
    force_rsp = 0;
    n_assert += 4;
    if (bus.proto_err !== 1'b1) begin n_fail++;
      $display("FAIL proto_err_set: got %b expected 1", bus.proto_err); end
    if (bus.inst_valid !== 1'b1) begin n_fail++;
      $display("FAIL proto_inst_valid: got %b expected 1", bus.inst_valid); end
    if (bus.inst_data !== head.data) begin n_fail++;
      $display("FAIL proto_head_data: got %h expected %h", bus.inst_data, head.data); end
    if (bus.inst_pc !== head.pc) begin n_fail++;
      $display("FAIL proto_head_pc: got %h expected %h", bus.inst_pc, head.pc); end
    ready_v = 1;
    repeat (6) cycle();
    n_assert++;
    if (bus.proto_err !== 1'b1) begin n_fail++;
      $display("FAIL proto_err_sticky: got %b expected 1", bus.proto_err); end
    rst = 1'b0;
    #1;
    n_assert += 3;
    if (bus.proto_err !== 1'b0) begin n_fail++;
      $display("FAIL proto_err_clear: got %b expected 0", bus.proto_err); end
    if (bus.inst_valid !== 1'b0) begin n_fail++;
      $display("FAIL midrst_inst_valid: got %b expected 0", bus.inst_valid); end
    if (bus.fetch_pc !== 32'h0) begin n_fail++;
      $display("FAIL midrst_fetch_pc: got %h expected 0", bus.fetch_pc); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_jump();
    test_wrap();
    test_back_to_back();
    test_proto_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
